// File: rtl/sha256_block_sequencer.sv
// sha256_block_sequencer: sequences one padded 512-bit block at a time through
// the message scheduler and compression core. It keeps the running hash state
// H0..H7 across the blocks of a message and returns the digest over a
// valid/ready handshake. A watchdog aborts to ERROR when the datapath stalls.
module sha256_block_sequencer #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         blk_valid,
   output logic         blk_ready,
   input  logic [511:0] blk_data,
   input  logic         blk_first,
   input  logic         blk_last,
   output logic         sched_load,
   output logic [511:0] sched_block,
   input  logic         sched_active,
   output logic         comp_start,
   output logic [255:0] comp_hash_in,
   input  logic         comp_done,
   input  logic [255:0] comp_hash_out,
   output logic         digest_valid,
   output logic [255:0] digest,
   input  logic         digest_ready,
   output logic [15:0]  blk_count,
   output logic         err,
   input  logic         err_clr
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_START  = 3'd3;
   localparam logic [2:0] S_RUN    = 3'd4;
   localparam logic [2:0] S_ACCUM  = 3'd5;
   localparam logic [2:0] S_OUTPUT = 3'd6;
   localparam logic [2:0] S_ERROR  = 3'd7;

   // SHA-256 initial hash value, H0 in the top word.
   localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                  32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   localparam logic [15:0] TIMEOUT = 16'(TIMEOUT_CYCLES);

   logic [2:0]   state;
   logic [2:0]   state_nxt;
   logic [255:0] h_q;        // running hash state H0..H7
   logic [255:0] cap_q;      // working variables captured on comp_done
   logic         msg_open;   // a message has started and not yet finished
   logic         last_q;     // latched blk_last of the block in flight
   logic [15:0]  wd_cnt;
   logic [15:0]  wd_inc;
   logic         timeout;
   logic         accept;

   assign accept  = blk_valid && (state == S_IDLE);
   assign wd_inc  = wd_cnt + 16'd1;
   // The watchdog fires on the last permitted cycle so the state machine
   // leaves for ERROR instead of spending another cycle in WAIT_SCHED or RUN.
   assign timeout = ((state == S_WAIT) || (state == S_RUN)) && (wd_inc == TIMEOUT);

   // Moore decodes of the state; hash state is exposed continuously.
   assign blk_ready    = (state == S_IDLE);
   assign sched_load   = (state == S_LOAD);
   assign comp_start   = (state == S_START);
   assign digest_valid = (state == S_OUTPUT);
   assign comp_hash_in = h_q;
   assign digest       = h_q;

   // Next-state selection; the watchdog takes priority over datapath handshakes.
   always_comb begin
      // NOTE: default assignment first so no path through the case leaves
      // state_nxt unassigned, which would otherwise infer a latch.
      state_nxt = state;
      case (state)
         S_IDLE:   if (blk_valid) state_nxt = (blk_first || msg_open) ? S_LOAD : S_ERROR;
         S_LOAD:   state_nxt = S_WAIT;
         S_WAIT: begin
            if (timeout)           state_nxt = S_ERROR;
            else if (sched_active) state_nxt = S_START;
         end
         S_START:  state_nxt = S_RUN;
         S_RUN: begin
            if (timeout)        state_nxt = S_ERROR;
            else if (comp_done) state_nxt = S_ACCUM;
         end
         S_ACCUM:  state_nxt = last_q ? S_OUTPUT : S_IDLE;
         S_OUTPUT: if (digest_ready) state_nxt = S_IDLE;
         S_ERROR:  state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: non-blocking assignments for all clocked state so every register
      // samples pre-edge values regardless of block evaluation order.
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Watchdog: restarts on the cycle before WAIT_SCHED/RUN, counts inside them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                      wd_cnt <= '0;
      else if ((state == S_LOAD) || (state == S_START)) wd_cnt <= '0;
      else if ((state == S_WAIT) || (state == S_RUN))   wd_cnt <= wd_inc;
   end

   // Block latch, hash accumulation and message bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sched_block <= '0;
         last_q      <= 1'b0;
         h_q         <= '0;
         cap_q       <= '0;
         msg_open    <= 1'b0;
         blk_count   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  sched_block <= blk_data;
                  last_q      <= blk_last;
                  if (blk_first) begin
                     // A new message silently abandons any open one.
                     h_q       <= IV;
                     blk_count <= '0;
                     msg_open  <= 1'b1;
                  end
               end
            end
            S_RUN: if (comp_done) cap_q <= comp_hash_out;
            S_ACCUM: begin
               // Independent 32-bit sums: carries never cross word boundaries.
               for (int i = 0; i < 8; i++)
                  h_q[32*i +: 32] <= h_q[32*i +: 32] + cap_q[32*i +: 32];
               if (blk_count != 16'hFFFF) blk_count <= blk_count + 16'd1;
            end
            S_OUTPUT: if (digest_ready) msg_open <= 1'b0;
            S_ERROR: begin
               msg_open  <= 1'b0;
               blk_count <= '0;
            end
            default: ;
         endcase
      end
   end

   // Sticky error flag; setting in ERROR wins over a simultaneous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   err <= 1'b0;
      else if (state == S_ERROR) err <= 1'b1;
      else if (err_clr)          err <= 1'b0;
   end

endmodule
